// File: rtl/dom_and_2share_seq_if.sv
// Operand, randomness, multiplier and result signals of the 2-share DOM AND sequencer.
// The sequencer connects through the slave modport; master is the environment's view.
interface dom_and_2share_seq_if #(
    parameter int DW = 64
);
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] a0_i;
    logic [DW-1:0] a1_i;
    logic [DW-1:0] b0_i;
    logic [DW-1:0] b1_i;
    logic          rnd_req_o;
    logic          rnd_ack_i;
    logic [DW-1:0] rnd_i;
    logic [DW-1:0] dom_a0_o;
    logic [DW-1:0] dom_a1_o;
    logic [DW-1:0] dom_b0_o;
    logic [DW-1:0] dom_b1_o;
    logic          dom_c_valid_o;
    logic [DW-1:0] dom_c0_o;
    logic [DW-1:0] dom_c1_o;
    logic [DW-1:0] dom_q0_i;
    logic [DW-1:0] dom_q1_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] q0_o;
    logic [DW-1:0] q1_o;
    logic          busy_o;

    modport slave (
        input  in_valid_i, a0_i, a1_i, b0_i, b1_i, rnd_ack_i, rnd_i,
               dom_q0_i, dom_q1_i, out_ready_i,
        output in_ready_o, rnd_req_o, dom_a0_o, dom_a1_o, dom_b0_o, dom_b1_o,
               dom_c_valid_o, dom_c0_o, dom_c1_o, out_valid_o, q0_o, q1_o, busy_o
    );

    modport master (
        output in_valid_i, a0_i, a1_i, b0_i, b1_i, rnd_ack_i, rnd_i,
               dom_q0_i, dom_q1_i, out_ready_i,
        input  in_ready_o, rnd_req_o, dom_a0_o, dom_a1_o, dom_b0_o, dom_b1_o,
               dom_c_valid_o, dom_c0_o, dom_c1_o, out_valid_o, q0_o, q1_o, busy_o
    );
endinterface

// File: rtl/dom_and_2share_seq.sv
// Sequencer/result stage for a 2-share DOM AND: accept -> c_valid pulse next cycle -> result 3 cycles after accept.
// One word of randomness is buffered independently; randomness stalls extend RND, out_ready low holds OUT.
module dom_and_2share_seq #(
    parameter int DW       = 64,
    parameter bit ClearOps = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    dom_and_2share_seq_if.slave      io_bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RND    = 2'd1,
        S_SETTLE = 2'd2,
        S_OUT    = 2'd3
    } state_e;

    state_e        r_state;
    state_e        w_state_nxt;
    logic [DW-1:0] r_a0, r_a1, r_b0, r_b1;
    logic [DW-1:0] r_rnd;
    logic          r_rnd_vld;
    logic [DW-1:0] r_q0, r_q1;

    logic w_in_rdy;
    logic w_accept;
    logic w_consume;
    logic w_capture;
    logic w_out_vld;
    logic w_release;
    logic w_rnd_fill;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_rdy    = 1'b0;
        w_accept    = 1'b0;
        w_consume   = 1'b0;
        w_capture   = 1'b0;
        w_out_vld   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_rdy = 1'b1;
                if (io_bus.in_valid_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RND;
                end
            end
            S_RND: begin
                if (r_rnd_vld) begin
                    w_consume   = 1'b1;
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // multiplier register now holds the cross terms; its outputs are final
                w_capture   = 1'b1;
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                w_out_vld = 1'b1;
                if (io_bus.out_ready_i) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A word is used exactly once: the consume cycle always has the buffer full, so no refill can collide.
    assign w_rnd_fill = !r_rnd_vld && io_bus.rnd_ack_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rnd     <= '0;
            r_rnd_vld <= 1'b0;
        end else if (w_consume) begin
            r_rnd_vld <= 1'b0;
        end else if (w_rnd_fill) begin
            r_rnd     <= io_bus.rnd_i;
            r_rnd_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a0 <= '0;
            r_a1 <= '0;
            r_b0 <= '0;
            r_b1 <= '0;
        end else if (w_accept) begin
            r_a0 <= io_bus.a0_i;
            r_a1 <= io_bus.a1_i;
            r_b0 <= io_bus.b0_i;
            r_b1 <= io_bus.b1_i;
        end else if (w_release && ClearOps) begin
            r_a0 <= '0;
            r_a1 <= '0;
            r_b0 <= '0;
            r_b1 <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q0 <= '0;
            r_q1 <= '0;
        end else if (w_capture) begin
            r_q0 <= io_bus.dom_q0_i;
            r_q1 <= io_bus.dom_q1_i;
        end
    end

    assign io_bus.in_ready_o    = w_in_rdy;
    assign io_bus.rnd_req_o     = !r_rnd_vld;
    assign io_bus.dom_a0_o      = r_a0;
    assign io_bus.dom_a1_o      = r_a1;
    assign io_bus.dom_b0_o      = r_b0;
    assign io_bus.dom_b1_o      = r_b1;
    assign io_bus.dom_c_valid_o = w_consume;
    assign io_bus.dom_c0_o      = r_rnd;
    assign io_bus.dom_c1_o      = r_rnd;
    assign io_bus.out_valid_o   = w_out_vld;
    assign io_bus.q0_o          = r_q0;
    assign io_bus.q1_o          = r_q1;
    assign io_bus.busy_o        = (r_state != S_IDLE);

endmodule

// File: tb/tb_dom_and_2share_seq.sv
// Bench for dom_and_2share_seq (DW=8) with a behavioural DOM AND multiplier downstream.
// Expected results come from the unmasked product and a FIFO view of delivered randomness words.
module tb_dom_and_2share_seq;
    localparam int DW = 8;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   cyc;
    int   last_acc;
    logic [7:0] last_z;
    logic [7:0] rq[$];
    logic [7:0] m0_r, m1_r;

    dom_and_2share_seq_if #(.DW(DW)) bus ();

    dom_and_2share_seq #(.DW(DW), .ClearOps(1'b1)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // downstream multiplier: cross terms registered when randomness is valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_r <= '0;
            m1_r <= '0;
        end else if (bus.dom_c_valid_o) begin
            m0_r <= (bus.dom_a0_o & bus.dom_b1_o) ^ bus.dom_c0_o;
            m1_r <= (bus.dom_a1_o & bus.dom_b0_o) ^ bus.dom_c1_o;
        end
    end
    assign bus.dom_q0_i = (bus.dom_a0_o & bus.dom_b0_o) ^ m0_r;
    assign bus.dom_q1_i = (bus.dom_a1_o & bus.dom_b1_o) ^ m1_r;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // sample point; also tracks which randomness words the sequencer should hold
    task automatic smp();
        @(negedge clk);
        if (bus.dom_c_valid_o) begin
            if (rq.size() == 0) check_eq("rnd_avail_at_pulse", 64'(rq.size()), 64'd1);
            else last_z = rq.pop_front();
        end else if (bus.rnd_ack_i && rq.size() == 0) begin
            rq.push_back(bus.rnd_i);
        end
    endtask

    task automatic give_rnd(input logic [7:0] w);
        logic exp_req;
        bus.rnd_ack_i = 1'b1;
        bus.rnd_i     = w;
        exp_req       = (rq.size() == 0);
        smp();
        check_eq("rnd_req", 64'(bus.rnd_req_o), 64'(exp_req));
        nxt();
        bus.rnd_ack_i = 1'b0;
    endtask

    task automatic txn(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] b0,
                       input logic [7:0] b1, input int ack_at, input logic [7:0] ack_w,
                       input int hold, input bit pf, input logic [7:0] pf_w, input bit b2b);
        logic [7:0] exp_q, q0s, q1s;
        int k, pulse_k, pulses, out_k, exp_pk;
        bus.in_valid_i  = 1'b1;
        bus.a0_i        = a0;
        bus.a1_i        = a1;
        bus.b0_i        = b0;
        bus.b1_i        = b1;
        bus.rnd_ack_i   = 1'b0;
        bus.out_ready_i = 1'b0;
        exp_pk = (rq.size() != 0) ? 1 : ack_at + 1;
        exp_q  = (a0 ^ a1) & (b0 ^ b1);
        smp();
        check_eq("idle_in_ready", 64'(bus.in_ready_o), 64'd1);
        check_eq("idle_busy", 64'(bus.busy_o), 64'd0);
        check_eq("idle_out_valid", 64'(bus.out_valid_o), 64'd0);
        check_eq("idle_ops_zero", 64'({bus.dom_a0_o, bus.dom_a1_o, bus.dom_b0_o, bus.dom_b1_o}), 64'd0);
        if (b2b) check_eq("period", 64'(cyc - last_acc), 64'd4);
        last_acc = cyc;
        k = 0; pulse_k = 0; pulses = 0; out_k = 0;
        while (out_k == 0 && k < 40) begin
            nxt();
            k++;
            bus.in_valid_i  = 1'b0;
            bus.a0_i        = 8'($urandom);
            bus.a1_i        = 8'($urandom);
            bus.b0_i        = 8'($urandom);
            bus.b1_i        = 8'($urandom);
            bus.out_ready_i = (hold == 0);
            bus.rnd_ack_i   = (k == ack_at) || (pf && pulse_k != 0 && k == pulse_k + 1);
            bus.rnd_i       = (k == ack_at) ? ack_w : (bus.rnd_ack_i ? pf_w : 8'($urandom));
            smp();
            check_eq("ops_stable", 64'({bus.dom_a0_o, bus.dom_a1_o, bus.dom_b0_o, bus.dom_b1_o}),
                     64'({a0, a1, b0, b1}));
            if (bus.dom_c_valid_o) begin
                pulses++;
                pulse_k = k;
                check_eq("c0_word", 64'(bus.dom_c0_o), 64'(last_z));
                check_eq("c1_word", 64'(bus.dom_c1_o), 64'(last_z));
            end
            if (bus.out_valid_o) out_k = k;
        end
        check_eq("pulse_count", 64'(pulses), 64'd1);
        check_eq("pulse_cycle", 64'(pulse_k), 64'(exp_pk));
        check_eq("out_cycle", 64'(out_k), 64'(exp_pk + 2));
        check_eq("q_xor", 64'(bus.q0_o ^ bus.q1_o), 64'(exp_q));
        q0s = bus.q0_o;
        q1s = bus.q1_o;
        for (int h = 1; h <= hold; h++) begin
            nxt();
            bus.rnd_ack_i   = 1'b0;
            bus.out_ready_i = (h == hold);
            bus.in_valid_i  = 1'b1;
            bus.a0_i        = 8'($urandom);
            smp();
            check_eq("q0_held", 64'(bus.q0_o), 64'(q0s));
            check_eq("q1_held", 64'(bus.q1_o), 64'(q1s));
            check_eq("out_in_ready", 64'(bus.in_ready_o), 64'd0);
            check_eq("out_valid_held", 64'(bus.out_valid_o), 64'd1);
        end
        nxt();
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.rnd_ack_i   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] w;
        int ack_at;
        n_chk = 0; n_pass = 0; cyc = 0; last_acc = 0; last_z = '0;
        rst_n = 1'b0;
        bus.in_valid_i = 1'b0; bus.a0_i = '0; bus.a1_i = '0; bus.b0_i = '0; bus.b1_i = '0;
        bus.rnd_ack_i = 1'b0; bus.rnd_i = '0; bus.out_ready_i = 1'b0;
        nxt();
        smp();
        check_eq("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
        check_eq("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check_eq("rst_c_valid", 64'(bus.dom_c_valid_o), 64'd0);
        check_eq("rst_busy", 64'(bus.busy_o), 64'd0);
        check_eq("rst_rnd_req", 64'(bus.rnd_req_o), 64'd1);
        check_eq("rst_q", 64'({bus.q0_o, bus.q1_o}), 64'd0);
        nxt();
        rst_n = 1'b1;

        // preloaded randomness, directed operands (product 0x99)
        give_rnd(8'h5A);
        txn(8'h3C, 8'hA5, 8'h0F, 8'hF0, 0, 8'h00, 0, 1'b0, 8'h00, 1'b0);
        // randomness arrives 5 cycles after accept
        txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 5, 8'($urandom), 0, 1'b0, 8'h00, 1'b0);
        // consumer stalls 4 cycles
        give_rnd(8'($urandom));
        txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 8'h00, 4, 1'b0, 8'h00, 1'b0);
        // back-to-back with prefetched randomness
        give_rnd(8'h11);
        txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 8'h00, 0, 1'b1, 8'h22, 1'b0);
        txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 8'h00, 0, 1'b1, 8'h33, 1'b1);
        txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 8'h00, 0, 1'b0, 8'h00, 1'b1);
        // ack into a full buffer is ignored
        give_rnd(8'h77);
        give_rnd(8'hFF);
        txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 8'h00, 0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 8; i++) begin
            w = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                give_rnd(w);
                ack_at = 0;
            end else begin
                ack_at = $urandom_range(1, 4);
            end
            txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), ack_at, w,
                $urandom_range(0, 2), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
        end

        // asynchronous reset while in SETTLE
        give_rnd(8'($urandom));
        bus.in_valid_i = 1'b1;
        bus.a0_i = 8'($urandom); bus.a1_i = 8'($urandom);
        bus.b0_i = 8'($urandom); bus.b1_i = 8'($urandom);
        smp();
        nxt();
        bus.in_valid_i = 1'b0;
        smp();
        check_eq("pre_rst_pulse", 64'(bus.dom_c_valid_o), 64'd1);
        nxt();
        #2;
        rst_n = 1'b0;
        #1;
        rq.delete();
        check_eq("arst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check_eq("arst_q", 64'({bus.q0_o, bus.q1_o}), 64'd0);
        check_eq("arst_rnd_req", 64'(bus.rnd_req_o), 64'd1);
        check_eq("arst_busy", 64'(bus.busy_o), 64'd0);
        check_eq("arst_ops", 64'({bus.dom_a0_o, bus.dom_a1_o, bus.dom_b0_o, bus.dom_b1_o}), 64'd0);
        smp();
        nxt();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            smp();
            check_eq("post_rst_c_valid", 64'(bus.dom_c_valid_o), 64'd0);
            check_eq("post_rst_out_valid", 64'(bus.out_valid_o), 64'd0);
            check_eq("post_rst_busy", 64'(bus.busy_o), 64'd0);
            nxt();
        end
        // recovery after reset
        give_rnd(8'($urandom));
        txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 8'h00, 1, 1'b0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
